// File: rtl/riscv_pkg.sv
// Shared constants and the control-bus layout for the RV32I decode/execute slice.
// Build option: LUI_EN enables decoding of the LUI opcode.
package riscv_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned SIG_W   = 11;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_BR   = 3'b001;
    localparam logic [2:0] ALU_R    = 3'b010;
    localparam logic [2:0] ALU_I    = 3'b011;
    localparam logic [2:0] ALU_PASS = 3'b100;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_U = 2'b11;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam int unsigned SIG_ALUSRC   = 2;
    localparam int unsigned SIG_MEMTOREG = 3;
    localparam int unsigned SIG_REGWRITE = 4;
    localparam int unsigned SIG_MEMREAD  = 5;
    localparam int unsigned SIG_MEMWRITE = 6;
    localparam int unsigned SIG_BRANCH   = 7;

    // Field order matches the external signals[10:0] bit layout, MSB first.
    typedef struct packed {
        logic [2:0] alu_op;
        logic       branch;
        logic       mem_write;
        logic       mem_read;
        logic       reg_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic [1:0] imm_sel;
    } ctrl_t;

endpackage

// File: rtl/alu_core.sv
// RV32I ALU operations and branch-condition compare, purely combinational.
module alu_core
    import riscv_pkg::*;
(
    input  logic [2:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic            alt,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result_c,
    output logic            branch_c
);

    logic [4:0] shamt;
    logic       lt_s;
    logic       lt_u;
    logic       eq;

    assign shamt = b[4:0];
    assign lt_s  = $signed(a) < $signed(b);
    assign lt_u  = a < b;
    assign eq    = a == b;

    always_comb begin
        result_c = '0;
        branch_c = 1'b0;
        case (alu_op)
            ALU_ADD:  result_c = a + b;
            ALU_R, ALU_I: begin
                case (funct3)
                    // Only register-register ops may subtract; addi ignores bit 30.
                    F3_ADD:  result_c = (alu_op == ALU_R && alt) ? a - b : a + b;
                    F3_SLL:  result_c = a << shamt;
                    F3_SLT:  result_c = XLEN'(lt_s);
                    F3_SLTU: result_c = XLEN'(lt_u);
                    F3_XOR:  result_c = a ^ b;
                    F3_SR:   result_c = alt ? XLEN'($signed(a) >>> shamt) : a >> shamt;
                    F3_OR:   result_c = a | b;
                    default: result_c = a & b;
                endcase
            end
            ALU_BR: begin
                result_c = a - b;
                case (funct3)
                    F3_BEQ:  branch_c = eq;
                    F3_BNE:  branch_c = !eq;
                    F3_BLT:  branch_c = lt_s;
                    F3_BGE:  branch_c = !lt_s;
                    F3_BLTU: branch_c = lt_u;
                    F3_BGEU: branch_c = !lt_u;
                    default: branch_c = 1'b0;
                endcase
            end
            ALU_PASS: result_c = b;
            default:  result_c = '0;
        endcase
    end

endmodule

// File: rtl/riscv_decode_alu.sv
// Decode, immediate generation and ALU for the single-cycle RV32I core, plus an observation register.
// Build option: LUI_EN adds the LUI opcode (AluOp pass-through of the U-immediate).
module riscv_decode_alu
    import riscv_pkg::*;
(
    input  logic             clock,
    input  logic             clear,
    input  logic [XLEN-1:0]  I,
    input  logic [XLEN-1:0]  dataA,
    input  logic [XLEN-1:0]  dataB,
    output logic [SIG_W-1:0] signals,
    output logic [XLEN-1:0]  immGenOut,
    output logic [XLEN-1:0]  aluResult,
    output logic             branchFromAlu,
    output logic [XLEN-1:0]  lastResult,
    output logic             lastBranch
);

    ctrl_t           ctrl;
    logic [XLEN-1:0] b_operand;

    // Opcode decode into the control bus.
    always_comb begin
        ctrl = '0;
        case (I[6:0])
            OPC_R:      ctrl = '{alu_op: ALU_R,   branch: 1'b0, mem_write: 1'b0, mem_read: 1'b0,
                                 reg_write: 1'b1, mem_to_reg: 1'b0, alu_src: 1'b0, imm_sel: IMM_I};
            OPC_I:      ctrl = '{alu_op: ALU_I,   branch: 1'b0, mem_write: 1'b0, mem_read: 1'b0,
                                 reg_write: 1'b1, mem_to_reg: 1'b0, alu_src: 1'b1, imm_sel: IMM_I};
            OPC_LOAD:   ctrl = '{alu_op: ALU_ADD, branch: 1'b0, mem_write: 1'b0, mem_read: 1'b1,
                                 reg_write: 1'b1, mem_to_reg: 1'b1, alu_src: 1'b1, imm_sel: IMM_I};
            OPC_STORE:  ctrl = '{alu_op: ALU_ADD, branch: 1'b0, mem_write: 1'b1, mem_read: 1'b0,
                                 reg_write: 1'b0, mem_to_reg: 1'b0, alu_src: 1'b1, imm_sel: IMM_S};
            OPC_BRANCH: ctrl = '{alu_op: ALU_BR,  branch: 1'b1, mem_write: 1'b0, mem_read: 1'b0,
                                 reg_write: 1'b0, mem_to_reg: 1'b0, alu_src: 1'b0, imm_sel: IMM_B};
`ifdef LUI_EN
            OPC_LUI:    ctrl = '{alu_op: ALU_PASS, branch: 1'b0, mem_write: 1'b0, mem_read: 1'b0,
                                 reg_write: 1'b1, mem_to_reg: 1'b0, alu_src: 1'b1, imm_sel: IMM_U};
`endif
            default:    ctrl = '0;
        endcase
    end

    assign signals = ctrl;

    always_comb begin
        immGenOut = '0;
        case (ctrl.imm_sel)
            IMM_I:   immGenOut = {{20{I[31]}}, I[31:20]};
            IMM_S:   immGenOut = {{20{I[31]}}, I[31:25], I[11:7]};
            IMM_B:   immGenOut = {{19{I[31]}}, I[31], I[7], I[30:25], I[11:8], 1'b0};
            default: immGenOut = {I[31:12], 12'b0};
        endcase
    end

    assign b_operand = ctrl.alu_src ? immGenOut : dataB;

    alu_core u_alu_core (
        .alu_op   (ctrl.alu_op),
        .funct3   (I[14:12]),
        .alt      (I[30]),
        .a        (dataA),
        .b        (b_operand),
        .result_c (aluResult),
        .branch_c (branchFromAlu)
    );

    // Observation register: last result and last taken-branch condition.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            lastResult <= '0;
            lastBranch <= 1'b0;
        end else begin
            lastResult <= aluResult;
            lastBranch <= branchFromAlu & signals[SIG_BRANCH];
        end
    end

endmodule

// File: tb/tb_riscv_decode_alu.sv
// Directed self-checking bench for riscv_decode_alu; expectations are hand-computed.
// Honours LUI_EN when the bench and RTL are compiled with it.
module tb_riscv_decode_alu;

    logic        clock;
    logic        clear;
    logic [31:0] I;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [10:0] signals;
    logic [31:0] immGenOut;
    logic [31:0] aluResult;
    logic        branchFromAlu;
    logic [31:0] lastResult;
    logic        lastBranch;

    int vectors;
    int miscompares;

    riscv_decode_alu dut (
        .clock         (clock),
        .clear         (clear),
        .I             (I),
        .dataA         (dataA),
        .dataB         (dataB),
        .signals       (signals),
        .immGenOut     (immGenOut),
        .aluResult     (aluResult),
        .branchFromAlu (branchFromAlu),
        .lastResult    (lastResult),
        .lastBranch    (lastBranch)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic apply(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b);
        I     = instr;
        dataA = a;
        dataB = b;
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        clear = 1'b1;
        I     = '0;
        dataA = '0;
        dataB = '0;
        #2 clear = 1'b0;
        #1;
        check("reset_lastResult", lastResult, 32'h0);
        check("reset_lastBranch", 32'(lastBranch), 32'h0);
        @(negedge clock);
        clear = 1'b1;

        // addi x1,x0,1
        apply(32'h00100093, 32'h0, 32'h0);
        check("addi_signals", 32'(signals), 32'h314);
        check("addi_imm", immGenOut, 32'h1);
        check("addi_result", aluResult, 32'h1);
        check("addi_branch", 32'(branchFromAlu), 32'h0);
        @(posedge clock); #1;
        check("addi_lastResult", lastResult, 32'h1);

        // addi with bit 30 set must still add
        apply(32'h40000093, 32'h0, 32'h0);
        check("addi_bit30_result", aluResult, 32'h400);

        // bne +8
        apply(32'h00209463, 32'h1, 32'h2);
        check("bne_signals", 32'(signals), 32'h182);
        check("bne_imm", immGenOut, 32'h8);
        check("bne_taken", 32'(branchFromAlu), 32'h1);
        @(posedge clock); #1;
        check("bne_lastBranch", 32'(lastBranch), 32'h1);
        check("bne_lastResult", lastResult, 32'hFFFFFFFF);
        apply(32'h00209463, 32'h2, 32'h2);
        check("bne_not_taken", 32'(branchFromAlu), 32'h0);

        // bge -8, then bgeu on same data
        apply(32'hfe415ce3, 32'hFFFFFFFF, 32'h1);
        check("bge_imm", immGenOut, 32'hFFFFFFF8);
        check("bge_signed", 32'(branchFromAlu), 32'h0);
        apply(32'hfe417ce3, 32'hFFFFFFFF, 32'h1);
        check("bgeu_unsigned", 32'(branchFromAlu), 32'h1);

        // sub, srai, slt, sltu
        apply(32'h40208033, 32'h5, 32'h7);
        check("sub_result", aluResult, 32'hFFFFFFFE);
        check("sub_branch", 32'(branchFromAlu), 32'h0);
        apply(32'h4010D093, 32'h80000000, 32'h0);
        check("srai_result", aluResult, 32'hC0000000);
        apply(32'h0020a033, 32'hFFFFFFFF, 32'h1);
        check("slt_result", aluResult, 32'h1);
        apply(32'h0020b033, 32'hFFFFFFFF, 32'h1);
        check("sltu_result", aluResult, 32'h0);

        // memory ops and the all-zero word
        apply(32'h00202223, 32'h100, 32'h55);
        check("sw_signals", 32'(signals), 32'h045);
        check("sw_imm", immGenOut, 32'h4);
        check("sw_result", aluResult, 32'h104);
        apply(32'h00002183, 32'h0, 32'h0);
        check("lw_signals", 32'(signals), 32'h03C);
        apply(32'h00000000, 32'h0, 32'h0);
        check("zero_signals", 32'(signals), 32'h0);

        // lui
        apply(32'h12345037, 32'h0, 32'h0);
`ifdef LUI_EN
        check("lui_signals", 32'(signals), 32'h417);
        check("lui_result", aluResult, 32'h12345000);
`else
        check("lui_off_signals", 32'(signals), 32'h0);
`endif

        // load the register with a taken branch, then clear mid-cycle
        apply(32'h00209463, 32'h3, 32'h1);
        @(posedge clock); #1;
        check("pre_clear_lastResult", lastResult, 32'h2);
        check("pre_clear_lastBranch", 32'(lastBranch), 32'h1);
        #2 clear = 1'b0;
        #1;
        check("clear_lastResult", lastResult, 32'h0);
        check("clear_lastBranch", 32'(lastBranch), 32'h0);
        check("clear_comb_unaffected", aluResult, 32'h2);
        @(negedge clock);
        clear = 1'b1;
        @(posedge clock); #1;
        check("release_lastResult", lastResult, 32'h2);
        check("release_lastBranch", 32'(lastBranch), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
